// File: rtl/mdu_pkg.sv
// Shared CPU constants for the multiply/divide unit: operation encodings and
// default latencies, also consumed by the decoder and the stall unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // True for the four long-latency operations that occupy the unit.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at the start edge and held in temporaries until the busy window expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] C
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [31:0]   hi, lo, tmp_hi, tmp_lo;
    logic          tmp_keep;
    logic [CW-1:0] cnt;

    logic          is_mult, is_signed;
    logic [63:0]   ext_a, ext_b, prod;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic [31:0]   res_hi, res_lo;

    assign start = is_muldiv(MDUOp) & ~busy & ~req;

    always_comb begin
        is_mult   = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);
        is_signed = (MDUOp == MDU_MULT) || (MDUOp == MDU_DIV);

        // Low 64 bits of the extended product are exact for both signednesses.
        ext_a = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
        ext_b = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
        prod  = ext_a * ext_b;

        // Magnitude division keeps 0x80000000 / -1 well defined (wraps to itself).
        a_neg  = is_signed & A[31];
        b_neg  = is_signed & B[31];
        a_mag  = a_neg ? (~A + 32'd1) : A;
        b_mag  = b_neg ? (~B + 32'd1) : B;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

        res_hi = is_mult ? prod[63:32] : rem;
        res_lo = is_mult ? prod[31:0]  : quot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            tmp_hi   <= 32'd0;
            tmp_lo   <= 32'd0;
            tmp_keep <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            tmp_hi   <= res_hi;
            tmp_lo   <= res_lo;
            tmp_keep <= ~is_mult & (B == 32'd0);
            cnt      <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy     <= 1'b1;
        end else if (busy) begin
            // In-flight work ignores req and any new operation until it retires.
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                if (!tmp_keep) begin
                    hi <= tmp_hi;
                    lo <= tmp_lo;
                end
            end
        end else if (!req) begin
            if (MDUOp == MDU_MTHI) hi <= A;
            if (MDUOp == MDU_MTLO) lo <= A;
        end
    end

    always_comb begin
        C = 32'd0;
        if (MDUOp == MDU_MFHI) C = hi;
        else if (MDUOp == MDU_MFLO) C = lo;
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, HI/LO results, mthi/mtlo gating, req and
// mid-operation reset behaviour.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUOp;
    logic        req;
    logic        start, busy;
    logic [31:0] C;

    int total = 0;
    int passes = 0;
    int n;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUOp (MDUOp),
        .req   (req),
        .start (start),
        .busy  (busy),
        .C     (C)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        MDUOp = 4'd5;
        #1 check({tag, "_hi"}, C, exp_hi);
        MDUOp = 4'd6;
        #1 check({tag, "_lo"}, C, exp_lo);
        MDUOp = 4'd0;
        #1;
    endtask

    // Issue one mult/div, check start, then count busy cycles (bounded).
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles);
        MDUOp = op; A = a; B = b;
        #1 check({tag, "_start"}, {31'd0, start}, 32'd1);
        tick();
        MDUOp = 4'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_cycles"}, n, exp_cycles);
    endtask

    task automatic write_reg(input logic [3:0] op, input logic [31:0] a);
        MDUOp = op; A = a;
        tick();
        MDUOp = 4'd0;
    endtask

    initial begin
        reset = 1'b1; A = 32'd0; B = 32'd0; MDUOp = 4'd0; req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        read_hilo("reset", 32'd0, 32'd0);

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Starts in the cycle right after busy fell.
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
        read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("divu0", 4'd4, 32'd77, 32'd0, 10);
        read_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        read_hilo("divovf", 32'h0000_0000, 32'h8000_0000);

        run_op("divu", 4'd4, 32'd100, 32'd7, 10);
        read_hilo("divu", 32'd2, 32'd14);

        write_reg(4'd7, 32'h1234_5678);
        write_reg(4'd8, 32'h0BAD_F00D);
        read_hilo("mtx", 32'h1234_5678, 32'h0BAD_F00D);

        // Divide by zero keeps HI/LO, so a stray mthi/mtlo while busy would show.
        MDUOp = 4'd4; A = 32'd5; B = 32'd0;
        #1 check("busy_start", {31'd0, start}, 32'd1);
        tick();
        MDUOp = 4'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 2) begin
                MDUOp = 4'd1; A = 32'd2; B = 32'd3;
                #1 check("busy_nostart", {31'd0, start}, 32'd0);
            end else if (n == 3) begin
                MDUOp = 4'd7; A = 32'hDEAD_BEEF;
            end else if (n == 4) begin
                MDUOp = 4'd8; A = 32'hCAFE_F00D;
            end else begin
                MDUOp = 4'd0;
            end
            tick();
        end
        MDUOp = 4'd0;
        check("busy_cycles", n, 10);
        read_hilo("busy_ign", 32'h1234_5678, 32'h0BAD_F00D);

        // req suppresses start and mthi.
        req = 1'b1;
        MDUOp = 4'd1; A = 32'd2; B = 32'd3;
        #1 check("req_start", {31'd0, start}, 32'd0);
        tick();
        check("req_busy", {31'd0, busy}, 32'd0);
        MDUOp = 4'd7; A = 32'h5555_AAAA;
        tick();
        req = 1'b0;
        MDUOp = 4'd0;
        read_hilo("req", 32'h1234_5678, 32'h0BAD_F00D);

        // Reset during the third busy cycle of a div.
        MDUOp = 4'd3; A = 32'd100; B = 32'd7;
        #1 check("rst_start", {31'd0, start}, 32'd1);
        tick();
        MDUOp = 4'd0;
        tick();
        tick();
        check("rst_busy3", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        read_hilo("rst", 32'd0, 32'd0);
        tick();
        check("rst_stays_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
